// File: rtl/rvga_types.sv
// Shared types for the register-file write path.
// Also carries the default starvation limit for the write arbiter.
`ifndef RVGA_STARVE_LIMIT_DEFAULT
`define RVGA_STARVE_LIMIT_DEFAULT 4
`endif

package rvga_types;

    typedef logic [4:0]  rvga_reg;
    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        RfarbIdle,
        RfarbWait,
        RfarbForce
    } rvga_rfarb_state_e;

    localparam int unsigned RVGA_STARVE_LIMIT_DEFAULT = `RVGA_STARVE_LIMIT_DEFAULT;

endpackage

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback (priority) and the
// long-latency unit, with a starvation guard that freezes the pipeline for one cycle.
module rf_write_arbiter
    import rvga_types::*;
#(
    parameter int unsigned STARVE_LIMIT = RVGA_STARVE_LIMIT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_w_v_i,
    input  logic        lu_v_i,
    input  logic [4:0]  lu_rd_i,
    input  logic [31:0] lu_data_i,
    output logic        lu_ready_o,
    output logic        stall_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_data_o,
    output logic        rf_w_v_o
);

    localparam logic [3:0] CntLast = 4'(STARVE_LIMIT - 1);

    rvga_rfarb_state_e state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    rvga_reg           rf_rd_q, rf_rd_d;
    rvga_word          rf_data_q, rf_data_d;
    logic              rf_w_v_q, rf_w_v_d;

    logic     stall;
    logic     wbq;
    logic     lu_grant;
    logic     sel_v;
    rvga_reg  sel_rd;
    rvga_word sel_data;

    assign stall = (state_q == RfarbForce);
    // A held WB request is not consumed during the freeze cycle.
    assign wbq   = wb_w_v_i && (wb_rd_i != '0) && !stall;

    always_comb begin
        state_d  = RfarbIdle;
        cnt_d    = '0;
        lu_grant = 1'b0;
        sel_v    = 1'b0;
        sel_rd   = '0;
        sel_data = '0;

        if (wbq) begin
            sel_v    = 1'b1;
            sel_rd   = wb_rd_i;
            sel_data = wb_data_i;
        end else if (lu_v_i) begin
            sel_v    = 1'b1;
            sel_rd   = lu_rd_i;
            sel_data = lu_data_i;
        end

        unique case (state_q)
            RfarbForce: begin
                lu_grant = lu_v_i;
            end
            default: begin
                if (lu_v_i) begin
                    // Same-rd conflict: WB is the younger writer, so the LU result is dropped.
                    if (!wbq || (lu_rd_i == '0) || (lu_rd_i == wb_rd_i)) begin
                        lu_grant = 1'b1;
                    end else if (cnt_q == CntLast) begin
                        state_d = RfarbForce;
                    end else begin
                        state_d = RfarbWait;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
        endcase

        rf_w_v_d  = sel_v && (sel_rd != '0);
        rf_rd_d   = rf_w_v_d ? sel_rd : '0;
        rf_data_d = rf_w_v_d ? sel_data : '0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RfarbIdle;
            cnt_q     <= '0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            rf_w_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            rf_w_v_q  <= rf_w_v_d;
        end
    end

    assign lu_ready_o = lu_grant && rst_i;
    assign stall_o    = stall;
    assign rf_rd_o    = rf_rd_q;
    assign rf_data_o  = rf_data_q;
    assign rf_w_v_o   = rf_w_v_q;

    // An LU result must be held until it is consumed.
    lu_hold_a : assert property (@(posedge clk_i) disable iff (!rst_i)
        (lu_v_i && !lu_ready_o) |=> lu_v_i);

    cnt_range_a : assert property (@(posedge clk_i) disable iff (!rst_i)
        cnt_q <= CntLast);

endmodule
